// File: rtl/timed_sequencer_pkg.sv
// Shared mode codes, FSM encoding and width helper for the timed phase sequencer.
package timed_sequencer_pkg;

  localparam logic [1:0] MODE_CYCLIC   = 2'd0;
  localparam logic [1:0] MODE_ONESHOT  = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sequencer_dwell_table.sv
// Per-phase dwell register file: one write port, one combinational read port.
module sequencer_dwell_table
  import timed_sequencer_pkg::*;
#(
  parameter int nOfPhases    = 4,
  parameter int CNT_W        = 17,
  parameter int IDX_W        = 2,
  parameter int defaultDwell = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [CNT_W-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [CNT_W-1:0] rdata
);

  logic [CNT_W-1:0] tab [nOfPhases];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < nOfPhases; i++) tab[i] <= CNT_W'(defaultDwell);
    end else if (we && (int'(waddr) < nOfPhases)) begin
      tab[waddr] <= wdata;
    end
  end

  // Reads the pre-write contents, so a same-edge write never affects the load.
  assign rdata = tab[raddr];

endmodule

// File: rtl/timed_sequencer.sv
// Multi-phase timed output sequencer with cyclic, one-shot and ping-pong stepping.
module timed_sequencer
  import timed_sequencer_pkg::*;
#(
  parameter int  maxTime      = 32'h10000,
  parameter int  nOfPhases    = 4,
  parameter int  defaultDwell = 1,
  localparam int CNT_W        = $clog2(maxTime + 1),
  localparam int IDX_W        = idx_width(nOfPhases)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             dwellWe,
  input  logic [IDX_W-1:0] dwellAddr,
  input  logic [CNT_W-1:0] dwellData,
  output logic [IDX_W-1:0] out,
  output logic             phaseStart,
  output logic             wrap,
  output logic             done,
  output logic             running
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(nOfPhases - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_down_q, dir_down_d;
  logic [1:0]       mode_q, mode_d;
  logic             ps_q, ps_d, wrap_q, wrap_d;

  logic [IDX_W-1:0] adv_idx, rd_addr;
  logic             adv_dir_down, adv_done, adv_wrap;
  logic [CNT_W-1:0] rd_data;

  // A stored dwell of 0 behaves as 1, so the reload never underflows.
  function automatic logic [CNT_W-1:0] reload(input logic [CNT_W-1:0] d);
    return (d == '0) ? '0 : d - CNT_W'(1);
  endfunction

  sequencer_dwell_table #(
    .nOfPhases   (nOfPhases),
    .CNT_W       (CNT_W),
    .IDX_W       (IDX_W),
    .defaultDwell(defaultDwell)
  ) u_table (
    .clk  (clk),
    .reset(reset),
    .we   (dwellWe),
    .waddr(dwellAddr),
    .wdata(dwellData),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  // Successor phase for the latched mode, evaluated whenever a phase ends.
  always_comb begin
    adv_idx      = idx_q + IDX_W'(1);
    adv_dir_down = dir_down_q;
    adv_done     = 1'b0;
    case (mode_q)
      MODE_ONESHOT: begin
        if (idx_q == LAST) begin
          adv_idx  = idx_q;
          adv_done = 1'b1;
        end
      end
      MODE_PINGPONG: begin
        if (nOfPhases == 1) begin
          adv_idx = '0;
        end else if (!dir_down_q) begin
          if (idx_q == LAST) begin
            adv_idx      = idx_q - IDX_W'(1);
            adv_dir_down = 1'b1;
          end
        end else if (idx_q == '0) begin
          adv_idx      = IDX_W'(1);
          adv_dir_down = 1'b0;
        end else begin
          adv_idx = idx_q - IDX_W'(1);
        end
      end
      default: begin
        if (idx_q == LAST) adv_idx = '0;
      end
    endcase
    adv_wrap = (mode_q != MODE_ONESHOT) && (adv_idx == '0);
  end

  assign rd_addr = (state_q == S_RUN) ? adv_idx : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      dir_down_q <= 1'b0;
      mode_q     <= MODE_CYCLIC;
      ps_q       <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      dir_down_q <= dir_down_d;
      mode_q     <= mode_d;
      ps_q       <= ps_d;
      wrap_q     <= wrap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    dir_down_d = dir_down_q;
    mode_d     = mode_q;
    ps_d       = 1'b0;
    wrap_d     = 1'b0;
    if (!enable) begin
      state_d    = S_IDLE;
      idx_d      = '0;
      cnt_d      = '0;
      dir_down_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d    = S_RUN;
          idx_d      = '0;
          cnt_d      = reload(rd_data);
          dir_down_d = 1'b0;
          mode_d     = mode;
          ps_d       = 1'b1;
        end
        S_RUN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (adv_done) begin
            state_d = S_DONE;
          end else begin
            idx_d      = adv_idx;
            dir_down_d = adv_dir_down;
            cnt_d      = reload(rd_data);
            ps_d       = 1'b1;
            wrap_d     = adv_wrap;
          end
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    out        = idx_q;
    phaseStart = ps_q;
    wrap       = wrap_q;
    done       = (state_q == S_DONE);
    running    = (state_q == S_RUN);
  end

endmodule
